// File: rtl/uart_receiver.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, LSB-first
// shift register, single-cycle o_valid / o_frame_err pulses.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low (start edge)
// START     | counting to mid start bit, then re-checking rx_s (false start)
// DATA      | sampling DATAWIDTH data bits, one per bit period, LSB first
// STOP      | sampling the stop bit; high -> o_valid, low -> o_frame_err
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_receiver #(
    parameter int DATAWIDTH    = 8,
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx_data,
    output logic [DATAWIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATAWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATAWIDTH-1:0] shift, shift_nxt;
    logic [DATAWIDTH-1:0] data_nxt;
    logic                 valid_nxt, ferr_nxt;

    // Bring the asynchronous serial line into the clk domain; idles high.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_data;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_cnt     <= bit_nxt;
            shift       <= shift_nxt;
            o_data      <= data_nxt;
            o_valid     <= valid_nxt;
            o_frame_err <= ferr_nxt;
        end
    end

    // Next-state and datapath decisions; the baud counter restarts at 0 on every sample.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        data_nxt  = o_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift[DATAWIDTH-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_cnt + BW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized frame stimulus checked against a frame-level event model.
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int DW  = 8;
    localparam int LAT = 2 + CPB / 2 + (DW + 1) * CPB;

    typedef struct {
        longint     cyc;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic          i_rx_data;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_frame_err;
    logic          o_busy;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    exp_t   q[$];
    logic [7:0] model_data = 8'h00;
    int     valid_cnt = 0;
    int     ferr_cnt  = 0;
    longint last_evt_cyc = 0;
    longint last_start   = 0;

    uart_receiver #(.DATAWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .i_rx_data  (i_rx_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one full frame starting at the current negedge; leaves the line at the stop value.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        last_start = cyc + 1;
        i_rx_data  = 1'b0;
        e.cyc  = last_start + LAT;
        e.err  = ~stop;
        e.data = d;
        q.push_back(e);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            i_rx_data = d[i];
            repeat (CPB) @(negedge clk);
        end
        i_rx_data = stop;
        repeat (CPB) @(negedge clk);
    endtask

    // Compare every cycle against the expected-event queue and the held data value.
    always @(negedge clk) begin
        if (i_reset_n) begin
            exp_t e;
            chk("valid_ferr_exclusive", {31'd0, o_valid & o_frame_err}, 32'd0);
            if (o_valid || o_frame_err) begin
                if (o_valid) valid_cnt++;
                if (o_frame_err) ferr_cnt++;
                last_evt_cyc = cyc;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse actual valid=%0b ferr=%0b data=%0h required no pulse (cycle %0d)",
                             o_valid, o_frame_err, o_data, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.err != o_frame_err || cyc < e.cyc - 1 || cyc > e.cyc + 1 ||
                        (o_valid && o_data != e.data)) begin
                        failures++;
                        $display("FAIL frame_event actual cyc=%0d ferr=%0b data=%0h required cyc=%0d+-1 ferr=%0b data=%0h",
                                 cyc, o_frame_err, o_data, e.cyc, e.err, e.data);
                    end
                    if (o_valid) model_data = e.data;
                end
            end else if (q.size() != 0 && cyc > q[0].cyc + 1) begin
                checks++;
                failures++;
                $display("FAIL missed_event actual none by cyc=%0d required ferr=%0b data=%0h at cyc=%0d",
                         cyc, q[0].err, q[0].data, q[0].cyc);
                void'(q.pop_front());
            end
            chk("o_data_hold", {24'd0, o_data}, {24'd0, model_data});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0;
        logic [7:0] d;
        logic       s;
        i_reset_n = 1'b0;
        i_rx_data = 1'b1;
        idle(3);
        chk("rst_o_data", {24'd0, o_data}, 32'd0);
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_ferr", {31'd0, o_frame_err}, 32'd0);
        chk("rst_o_busy", {31'd0, o_busy}, 32'd0);
        i_reset_n = 1'b1;
        idle(20);

        // Single frame 0x33 and its latency.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h33, 1'b1);
        i_rx_data = 1'b1;
        idle(10);
        chk("frame33_data", {24'd0, o_data}, 32'h33);
        chk("frame33_valid_cnt", valid_cnt, v0 + 1);
        chk("frame33_ferr_cnt", ferr_cnt, f0);
        chk("frame33_latency_in_range",
            {31'd0, (last_evt_cyc - last_start >= 153) && (last_evt_cyc - last_start <= 155)}, 32'd1);

        // Back-to-back frames.
        v0 = valid_cnt;
        send_frame(8'hAA, 1'b1);
        send_frame(8'h0F, 1'b1);
        i_rx_data = 1'b1;
        idle(10);
        chk("b2b_data", {24'd0, o_data}, 32'h0F);
        chk("b2b_valid_cnt", valid_cnt, v0 + 2);

        // Low stop bit: frame error, data held, busy while the line stays low.
        f0 = ferr_cnt; v0 = valid_cnt;
        send_frame(8'h55, 1'b0);
        idle(10);
        chk("ferr_busy_low_line", {31'd0, o_busy}, 32'd1);
        chk("ferr_data_held", {24'd0, o_data}, 32'h0F);
        chk("ferr_cnt", ferr_cnt, f0 + 1);
        chk("ferr_no_valid", valid_cnt, v0);
        i_rx_data = 1'b1;
        idle(10);
        chk("ferr_busy_released", {31'd0, o_busy}, 32'd0);

        // Short glitch is a false start.
        v0 = valid_cnt; f0 = ferr_cnt;
        i_rx_data = 1'b0;
        idle(CPB / 4);
        i_rx_data = 1'b1;
        idle(30);
        chk("glitch_busy", {31'd0, o_busy}, 32'd0);
        chk("glitch_valid_cnt", valid_cnt, v0);
        chk("glitch_ferr_cnt", ferr_cnt, f0);

        // Reset during bit 4 of a frame, then frame 0xC3.
        i_rx_data = 1'b0;
        idle(CPB);
        d = 8'h96;
        for (int i = 0; i < 4; i++) begin
            i_rx_data = d[i];
            idle(CPB);
        end
        i_rx_data = d[4];
        idle(CPB / 2);
        i_reset_n  = 1'b0;
        model_data = 8'h00;
        i_rx_data  = 1'b1;
        idle(2);
        chk("midrst_o_data", {24'd0, o_data}, 32'd0);
        chk("midrst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_o_ferr", {31'd0, o_frame_err}, 32'd0);
        chk("midrst_o_busy", {31'd0, o_busy}, 32'd0);
        i_reset_n = 1'b1;
        idle(20);
        send_frame(8'hC3, 1'b1);
        i_rx_data = 1'b1;
        idle(10);
        chk("after_rst_data", {24'd0, o_data}, 32'hC3);

        // Break: three frame times low gives exactly one frame error.
        f0 = ferr_cnt;
        begin
            exp_t e;
            e.cyc  = cyc + 1 + LAT;
            e.err  = 1'b1;
            e.data = 8'h00;
            q.push_back(e);
        end
        i_rx_data = 1'b0;
        idle(3 * (DW + 2) * CPB);
        i_rx_data = 1'b1;
        idle(20);
        chk("break_one_ferr", ferr_cnt, f0 + 1);
        send_frame(8'h01, 1'b1);
        i_rx_data = 1'b1;
        idle(10);
        chk("after_break_data", {24'd0, o_data}, 32'h01);

        // Randomized frames, random stop bits and gaps (including zero gap).
        for (int n = 0; n < 30; n++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, s);
            if (s) begin
                idle($urandom_range(0, 12));
            end else begin
                i_rx_data = 1'b1;
                idle($urandom_range(4, 12));
            end
            i_rx_data = 1'b1;
        end

        i_rx_data = 1'b1;
        idle(200);
        chk("queue_drained", q.size(), 0);
        chk("final_busy", {31'd0, o_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
